// File: rtl/gate_tree_pkg.sv
// rtl/gate_tree_pkg.sv - shared op encoding and bitwise gate helpers for gate_tree_pipe
package gate_tree_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    // Per-bit identity used to pad unused lanes; replicate across the lane width.
    function automatic logic op_identity(input op_e op);
        logic ident;
        case (op)
            OP_AND, OP_NAND: ident = 1'b1;
            default:         ident = 1'b0;
        endcase
        return ident;
    endfunction

    // NAND combines as AND; the inversion is applied once after the last level.
    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_tree_stage.sv
// rtl/gate_tree_stage.sv - one register level of the gate tree: pairwise combine plus valid/op tag
module gate_tree_stage
    import gate_tree_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       prev_valid,
    input  logic [2*N_OUT*WIDTH-1:0]   prev_data,
    input  logic [1:0]                 prev_op,
    output logic                       valid,
    output logic [N_OUT*WIDTH-1:0]     data,
    output logic [1:0]                 op
);

    logic                   valid_q, valid_d;
    logic [N_OUT*WIDTH-1:0] data_q, data_d;
    logic [1:0]             op_q, op_d;
    logic [N_OUT*WIDTH-1:0] comb_data;
    op_e                    prev_tag;

    always_comb begin
        prev_tag  = op_e'(prev_op);
        comb_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            for (int b = 0; b < WIDTH; b++) begin
                comb_data[i*WIDTH + b] = apply_op(prev_tag,
                                                  prev_data[(2*i)*WIDTH + b],
                                                  prev_data[(2*i+1)*WIDTH + b]);
            end
        end

        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        // Loading from an empty predecessor drops valid, collapsing the bubble.
        if (load) begin
            valid_d = prev_valid;
            if (prev_valid) begin
                data_d = comb_data;
                op_d   = prev_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= 2'b00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign op    = op_q;

endmodule

// File: rtl/gate_tree_pipe.sv
// rtl/gate_tree_pipe.sv - pipelined NUM_IN-lane gate reduction tree; GATE_TREE_PERF_EN adds out_count
module gate_tree_pipe
    import gate_tree_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data
`ifdef GATE_TREE_PERF_EN
    ,
    output logic [15:0]             out_count
`endif
);

    localparam int LEVELS  = $clog2(NUM_IN);
    localparam int PAD_IN  = 2**LEVELS;
    localparam int TOTAL_W = (2*PAD_IN - 1) * WIDTH;

    // All levels packed back to back: level 0 is the padded input, level s has PAD_IN>>s lanes.
    function automatic int lvl_off(input int s);
        return (2*PAD_IN - 2*(PAD_IN >> s)) * WIDTH;
    endfunction

    logic [TOTAL_W-1:0]      lvl_data;
    logic [2*LEVELS+1:0]     lvl_op;
    logic [LEVELS:0]         lvl_valid;
    logic [LEVELS+1:1]       lvl_ready;
    logic [PAD_IN*WIDTH-1:0] pad_data;
    logic [WIDTH-1:0]        last_data;
    logic [1:0]              last_op;

    always_comb begin
        pad_data = {(PAD_IN*WIDTH){op_identity(op_e'(in_op))}};
        pad_data[NUM_IN*WIDTH-1:0] = in_data;
    end

    assign lvl_data[PAD_IN*WIDTH-1:0] = pad_data;
    assign lvl_op[1:0]                = in_op;
    assign lvl_valid[0]               = in_valid;

    always_comb begin
        lvl_ready[LEVELS+1] = out_ready;
        for (int s = LEVELS; s >= 1; s--) begin
            lvl_ready[s] = !lvl_valid[s] || lvl_ready[s+1];
        end
    end

    for (genvar s = 1; s <= LEVELS; s++) begin : g_stage
        localparam int N_OUT   = PAD_IN >> s;
        localparam int OFF_IN  = lvl_off(s-1);
        localparam int OFF_OUT = lvl_off(s);

        gate_tree_stage #(
            .WIDTH (WIDTH),
            .N_OUT (N_OUT)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .load       (lvl_ready[s]),
            .prev_valid (lvl_valid[s-1]),
            .prev_data  (lvl_data[OFF_IN +: 2*N_OUT*WIDTH]),
            .prev_op    (lvl_op[2*(s-1) +: 2]),
            .valid      (lvl_valid[s]),
            .data       (lvl_data[OFF_OUT +: N_OUT*WIDTH]),
            .op         (lvl_op[2*s +: 2])
        );
    end

    assign last_data = lvl_data[lvl_off(LEVELS) +: WIDTH];
    assign last_op   = lvl_op[2*LEVELS +: 2];

    assign in_ready  = lvl_ready[1];
    assign out_valid = lvl_valid[LEVELS];
    // NAND was reduced as AND; invert once on the registered final result.
    assign out_data  = (op_e'(last_op) == OP_NAND) ? ~last_data : last_data;

`ifdef GATE_TREE_PERF_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (in_valid && in_ready && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`else
`endif

endmodule

// File: tb/tb_gate_tree_pipe.sv
// tb/tb_gate_tree_pipe.sv - self-checking bench for gate_tree_pipe (NUM_IN=4 and NUM_IN=3 instances)
module tb_gate_tree_pipe;

    logic        clk;
    logic        rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] in_data4;
    logic [1:0]  in_op4;
    logic [7:0]  out_data4;

    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [23:0] in_data3;
    logic [1:0]  in_op3;
    logic [7:0]  out_data3;

`ifdef GATE_TREE_PERF_EN
    logic [15:0] out_count4, out_count3;
`endif

    int tests_run;
    int tests_failed;
    int acc4, dlv4;
    logic [7:0] q4[$];
    logic [7:0] q3[$];

    gate_tree_pipe #(.WIDTH(8), .NUM_IN(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .in_op     (in_op4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
`ifdef GATE_TREE_PERF_EN
        ,
        .out_count (out_count4)
`endif
    );

    gate_tree_pipe #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .in_op     (in_op3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3)
`ifdef GATE_TREE_PERF_EN
        ,
        .out_count (out_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight left-to-right fold over the real lanes; NAND is the inverted AND of all lanes.
    function automatic logic [7:0] ref_reduce(input logic [31:0] d, input logic [1:0] op, input int n);
        logic [7:0] acc;
        logic [7:0] lane;
        acc = d[7:0];
        for (int k = 1; k < n; k++) begin
            lane = d[k*8 +: 8];
            case (op)
                2'b01:   acc = acc | lane;
                2'b10:   acc = acc ^ lane;
                default: acc = acc & lane;
            endcase
        end
        if (op == 2'b11) acc = ~acc;
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven; scores the upcoming rising edge.
    task automatic step();
        #1;
        if (rst) begin
            q4.delete();
            q3.delete();
        end else begin
            if (out_valid4 && out_ready4) begin
                dlv4++;
                chk("out4_expected", {31'd0, (q4.size() > 0)}, 32'd1);
                if (q4.size() > 0) chk("out4_data", {24'd0, out_data4}, {24'd0, q4.pop_front()});
            end
            if (in_valid4 && in_ready4) begin
                acc4++;
                q4.push_back(ref_reduce(in_data4, in_op4, 4));
            end
            if (out_valid3 && out_ready3) begin
                chk("out3_expected", {31'd0, (q3.size() > 0)}, 32'd1);
                if (q3.size() > 0) chk("out3_data", {24'd0, out_data3}, {24'd0, q3.pop_front()});
            end
            if (in_valid3 && in_ready3) begin
                q3.push_back(ref_reduce({8'h00, in_data3}, in_op3, 3));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int acc_base, dlv_base;
        logic [7:0] held;
        logic [31:0] r;

        tests_run = 0; tests_failed = 0; acc4 = 0; dlv4 = 0;
        rst = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; in_op4 = 2'b00; out_ready4 = 1'b1;
        in_valid3 = 1'b0; in_data3 = '0; in_op3 = 2'b00; out_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("rst_out_data", {24'd0, out_data4}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready4}, 32'd1);
        @(negedge clk);

        // Single AND transaction and its latency.
        in_valid4 = 1'b1; in_data4 = 32'hFF3CF0FF; in_op4 = 2'b00;
        step();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 10) begin
            step();
            lat++;
        end
        chk("and_latency", lat, 32'd2);
        chk("and_data", {24'd0, out_data4}, 32'h30);

        // Back-to-back op changes, results on consecutive cycles.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] seq_exp [4];
            seq_exp[0] = 8'h00; seq_exp[1] = 8'hFF; seq_exp[2] = 8'h00; seq_exp[3] = 8'hFF;
            in_valid4 = (i < 4);
            in_data4  = 32'h55AAF00F;
            in_op4    = 2'(i);
            #1;
            if (i >= 2) begin
                chk("b2b_valid", {31'd0, out_valid4}, 32'd1);
                chk("b2b_data", {24'd0, out_data4}, {24'd0, seq_exp[i-2]});
            end
            step();
        end

        // Stall: out_ready low while feeding continuously.
        acc_base = acc4; dlv_base = dlv4;
        out_ready4 = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1;
            in_data4  = $urandom();
            in_op4    = 2'($urandom_range(0, 3));
            #1;
            if (i >= 2) begin
                chk("stall_in_ready", {31'd0, in_ready4}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid4}, 32'd1);
                if (i == 2) held = out_data4;
                else chk("stall_hold", {24'd0, out_data4}, {24'd0, held});
            end
            step();
        end
        chk("stall_accepts", acc4 - acc_base, 32'd2);
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        for (int i = 0; i < 10 && q4.size() > 0; i++) step();
        chk("stall_drain_count", dlv4 - dlv_base, 32'd2);
        chk("stall_drain_empty", {31'd0, out_valid4}, 32'd0);

        // Reset with two results in flight.
        in_valid4 = 1'b1; in_data4 = $urandom(); in_op4 = 2'b01;
        step();
        in_data4 = $urandom(); in_op4 = 2'b10;
        step();
        in_valid4 = 1'b0; out_ready4 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; out_ready4 = 1'b1;
        chk("midrst_out_valid", {31'd0, out_valid4}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_stale", {31'd0, out_valid4}, 32'd0);
            step();
        end
        in_valid4 = 1'b1; in_data4 = 32'h78563412; in_op4 = 2'b10;
        step();
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 10) begin
            step();
            lat++;
        end
        chk("midrst_next_latency", lat, 32'd2);
        chk("midrst_next_data", {24'd0, out_data4}, 32'h08);
        step();

        // Three-lane instance exercises identity padding.
        in_valid3 = 1'b1; in_data3 = 24'hFF0FFF; in_op3 = 2'b00;
        step();
        in_data3 = 24'h040201; in_op3 = 2'b01;
        step();
        in_valid3 = 1'b0;
        chk("pad_and_valid", {31'd0, out_valid3}, 32'd1);
        chk("pad_and_data", {24'd0, out_data3}, 32'h0F);
        step();
        chk("pad_or_data", {24'd0, out_data3}, 32'h07);
        step();

        // Randomized traffic on both instances against the reference fold.
        for (int i = 0; i < 400; i++) begin
            in_valid4  = ($urandom_range(0, 3) != 0);
            out_ready4 = ($urandom_range(0, 3) != 0);
            in_data4   = $urandom();
            in_op4     = 2'($urandom_range(0, 3));
            in_valid3  = ($urandom_range(0, 1) != 0);
            out_ready3 = ($urandom_range(0, 2) != 0);
            r          = $urandom();
            in_data3   = r[23:0];
            in_op3     = 2'($urandom_range(0, 3));
            step();
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        in_valid3 = 1'b0; out_ready3 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("rand_q4_empty", q4.size(), 32'd0);
        chk("rand_q3_empty", q3.size(), 32'd0);

`ifdef GATE_TREE_PERF_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            in_data4 = $urandom();
            step();
        end
        in_valid4 = 1'b0;
        chk("perf_saturate", {16'd0, out_count4}, 32'h0000FFFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("perf_clear", {16'd0, out_count4}, 32'h00000000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
